rv_exec_pipe: RTL and testbench
===============================

// Module: rv_exec_pipe
// PURPOSE
//  Two-stage pipelined RV32/RV64 integer execute unit for OP (0110011) and OP-IMM (0010011).
//  Decodes the instruction, computes the ALU result and presents rd/result for register writeback.
//  Valid/ready handshakes on both sides. Sits between the operand-read and writeback stages of the core.
// PARAMETERS
//  XLEN        32  datapath width; legal values 32 or 64
//  RETIRE_W    16  width of the retired-instruction counter
//  (localparam SHW = $clog2(XLEN): shift-amount width)
// PORTS
//  clk          in   1         clock; all state updates on the rising edge
//  rst          in   1         synchronous, active-low reset
//  in_valid     in   1         instr/rs1_val/rs2_val valid
//  in_ready     out  1         stage D can accept this cycle
//  instr        in   32        RISC-V instruction word
//  rs1_val      in   XLEN      rs1 operand value
//  rs2_val      in   XLEN      rs2 operand value; unused for OP-IMM
//  out_valid    out  1         result valid
//  out_ready    in   1         writeback accepts the result
//  out_rd       out  5         destination register index
//  out_result   out  XLEN      ALU result
//  out_we       out  1         1 = write rd (legal instruction and rd != x0)
//  out_illegal  out  1         unsupported opcode, funct3 or funct7
//  retire_cnt   out  RETIRE_W  count of results accepted downstream; wraps to 0
// BEHAVIOUR
//  Reset (rst==0 at an edge): both stage valids = 0, so out_valid = 0.
//    out_rd, out_result, out_we, out_illegal and retire_cnt = 0.
//    Any in-flight ops are dropped, not completed.
//  Stage D: registers decoded op, the two operands (imm sign-extended from instr[31:20]) and rd.
//  Stage X: registers result, rd, we and illegal.
//  Latency: an input accepted at edge N gives out_valid=1 after edge N+1, with no stall.
//  Throughput: one op per cycle.
//  Handshake:
//    - Transfer occurs when valid && ready.
//    - X advances when !x_valid || out_ready.
//    - D advances when !d_valid || x_advance.
//    - in_ready = !d_valid || x_advance; it is combinational from out_ready, with no skid buffer.
//    - While out_valid && !out_ready, all out_* signals hold stable.
//  Ops:
//    - OP: ADD, SUB (funct7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA (funct7=0100000), OR, AND.
//    - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
//  Arithmetic and width rules:
//    - Add/sub are modulo 2^XLEN.
//    - SLT/SLTU return a 0/1 value zero-extended to XLEN.
//    - Shift amount = low SHW bits of rs2 or imm. SRA and SRAI replicate the MSB.
//  Illegal conditions:
//    - opcode is not OP or OP-IMM;
//    - OP funct7 is not 0000000 and not (0100000 with funct3 000 or 101);
//    - shift-imm upper bits (instr[31:25] for XLEN=32, instr[31:26] for XLEN=64)
//      are not 0 and not the SRAI pattern.
//    - An illegal op gives out_illegal=1, out_result=0, out_we=0. It still flows and retires.
//  rd == x0: the result is still computed and presented; out_we = 0.
//  retire_cnt increments on out_valid && out_ready and wraps from 2^RETIRE_W-1 to 0.
//  Simultaneous in/out transfer in a full pipe: both occur in the same cycle, with no bubble.
// CONFIGURATION
//  Macro RV_EXEC_MUL_EN:
//    - Defined: OP with funct7=0000001 and funct3 000/001/010/011 executes
//      MUL/MULH/MULHSU/MULHU, using the low or high XLEN bits of the 2*XLEN product.
//      The op is computed in stage X, with the same latency.
//    - Undefined: these encodings are illegal (out_illegal=1). No multiplier is instantiated.
// STRUCTURE
//  Package rv_exec_pkg:
//    - OPC_OP and OPC_OP_IMM constants;
//    - funct3/funct7 constants;
//    - alu_op_e enum (ADD..AND, plus MUL* when RV_EXEC_MUL_EN is defined, plus ILLEGAL).
//  Sub-module rv_alu: purely combinational (alu_op_e, a, b) -> result, parameterised by XLEN.
//    Instantiated in stage X.
//  Decode logic and handshake/pipeline registers stay in rv_exec_pipe.
// TESTING
//  1. XLEN=32, rs1=0x0000000F, rs2=0x0000000C:
//     ADD -> 0x1B; SUB -> 0x3; XOR -> 0x3; OR -> 0xF; AND -> 0xC; rd=2, out_we=1.
//  2. rs1=0xFF0000FF, rs2=0x4: SLL -> 0xF0000FF0; SRL -> 0x0FF0000F; SRA -> 0xFFF0000F.
//     SRAI with imm 4 gives the same result.
//  3. rs1=0x70000000, rs2=0xF0000000: SLT -> 0; SLTU -> 1.
//     SLTI with imm 0xFFF and rs1=0 -> 0; SLTIU -> 1.
//  4. Stream 4 ADDs with out_ready=0 for 3 cycles:
//     - in_ready drops after 2 accepts;
//     - out_* hold stable;
//     - on release all 4 results emerge in order;
//     - retire_cnt=4.
//  5. instr opcode 0000011, then OP with funct7=0000001 and RV_EXEC_MUL_EN undefined:
//     out_illegal=1, out_we=0, result=0. With the macro defined, MUL 0xF*0xC -> 0xB4.
//  6. rd=x0 ADD -> out_we=0. Assert rst=0 with both stages full:
//     the next cycle has out_valid=0 and retire_cnt=0; the first op after release has 2-cycle latency.

Source files
------------

// File: rtl/rv_exec_pkg.sv
// Shared encodings and the ALU operation enum for the RV32/RV64 execute pipe.
// RV_EXEC_MUL_EN adds the MUL/MULH/MULHSU/MULHU operations.
package rv_exec_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
`ifdef RV_EXEC_MUL_EN
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
`endif
    ALU_ILLEGAL
  } alu_op_e;

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU; ALU_ILLEGAL yields zero.
// The multiplier exists only when RV_EXEC_MUL_EN is defined.
module rv_alu
  import rv_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

`ifdef RV_EXEC_MUL_EN
  // One 2*XLEN multiplier; operand sign extension selects the MULH flavour.
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  always_comb begin
    mul_a = (op == ALU_MULH || op == ALU_MULHSU) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    mul_b = (op == ALU_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    prod  = mul_a * mul_b;
  end
`endif

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU:   result = XLEN'(a < b);
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
`ifdef RV_EXEC_MUL_EN
      ALU_MUL:    result = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result = prod[2*XLEN-1:XLEN];
`endif
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/rv_exec_pipe.sv
// Two-stage OP/OP-IMM execute pipe: stage D decodes, stage X runs the ALU.
// RV_EXEC_MUL_EN enables the M-extension multiply encodings.
module rv_exec_pipe
  import rv_exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [XLEN-1:0]     rs1_val,
  input  logic [XLEN-1:0]     rs2_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_rd,
  output logic [XLEN-1:0]     out_result,
  output logic                out_we,
  output logic                out_illegal,
  output logic [RETIRE_W-1:0] retire_cnt
);

  localparam int SHW = $clog2(XLEN);
  // Shift-immediate upper bits for SRAI: 0100000 (RV32) or 010000 (RV64).
  localparam logic [11:0] SRAI_HI = 12'd1 << (10 - SHW);

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [11:0]     shi;
  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_b;
  logic            unused_rs_idx;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign shi = instr[31:20] >> SHW;
  assign unused_rs_idx = ^instr[19:15];

  always_comb begin
    dec_op = ALU_ILLEGAL;
    dec_b  = (opc == OPC_OP) ? rs2_val : {{(XLEN-12){instr[31]}}, instr[31:20]};
    if (opc == OPC_OP) begin
      if (f7 == F7_BASE) begin
        case (f3)
          F3_ADD:  dec_op = ALU_ADD;
          F3_SLL:  dec_op = ALU_SLL;
          F3_SLT:  dec_op = ALU_SLT;
          F3_SLTU: dec_op = ALU_SLTU;
          F3_XOR:  dec_op = ALU_XOR;
          F3_SR:   dec_op = ALU_SRL;
          F3_OR:   dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end else if (f7 == F7_ALT && f3 == F3_ADD) begin
        dec_op = ALU_SUB;
      end else if (f7 == F7_ALT && f3 == F3_SR) begin
        dec_op = ALU_SRA;
`ifdef RV_EXEC_MUL_EN
      end else if (f7 == F7_MULDIV) begin
        case (f3)
          F3_MUL:    dec_op = ALU_MUL;
          F3_MULH:   dec_op = ALU_MULH;
          F3_MULHSU: dec_op = ALU_MULHSU;
          F3_MULHU:  dec_op = ALU_MULHU;
          default:   dec_op = ALU_ILLEGAL;
        endcase
`endif
      end
    end else if (opc == OPC_OP_IMM) begin
      case (f3)
        F3_ADD:  dec_op = ALU_ADD;
        F3_SLT:  dec_op = ALU_SLT;
        F3_SLTU: dec_op = ALU_SLTU;
        F3_XOR:  dec_op = ALU_XOR;
        F3_OR:   dec_op = ALU_OR;
        F3_AND:  dec_op = ALU_AND;
        F3_SLL:  dec_op = (shi == '0) ? ALU_SLL : ALU_ILLEGAL;
        default: dec_op = (shi == '0) ? ALU_SRL : (shi == SRAI_HI) ? ALU_SRA : ALU_ILLEGAL;
      endcase
    end
  end

  // Pipeline state
  logic                d_valid_q, d_valid_d, x_valid_q, x_valid_d;
  alu_op_e             d_op_q, d_op_d;
  logic [XLEN-1:0]     d_a_q, d_a_d, d_b_q, d_b_d;
  logic [4:0]          d_rd_q, d_rd_d, x_rd_q, x_rd_d;
  logic [XLEN-1:0]     x_result_q, x_result_d, alu_res;
  logic                x_we_q, x_we_d, x_ill_q, x_ill_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                x_adv, d_adv;

  rv_alu #(.XLEN(XLEN)) u_alu (.op(d_op_q), .a(d_a_q), .b(d_b_q), .result(alu_res));

  always_comb begin
    x_adv      = !x_valid_q || out_ready;
    d_adv      = !d_valid_q || x_adv;
    d_valid_d  = d_valid_q;
    d_op_d     = d_op_q;
    d_a_d      = d_a_q;
    d_b_d      = d_b_q;
    d_rd_d     = d_rd_q;
    x_valid_d  = x_valid_q;
    x_rd_d     = x_rd_q;
    x_result_d = x_result_q;
    x_we_d     = x_we_q;
    x_ill_d    = x_ill_q;
    retire_d   = retire_q + ((out_valid && out_ready) ? RETIRE_W'(1) : '0);
    if (d_adv) begin
      d_valid_d = in_valid;
      if (in_valid) begin
        d_op_d = dec_op;
        d_a_d  = rs1_val;
        d_b_d  = dec_b;
        d_rd_d = instr[11:7];
      end
    end
    // X only loads when it advances, so out_* hold under backpressure.
    if (x_adv) begin
      x_valid_d = d_valid_q;
      if (d_valid_q) begin
        x_rd_d     = d_rd_q;
        x_result_d = alu_res;
        x_ill_d    = (d_op_q == ALU_ILLEGAL);
        x_we_d     = (d_op_q != ALU_ILLEGAL) && (d_rd_q != 5'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_valid_q  <= 1'b0;
      d_op_q     <= ALU_ADD;
      d_a_q      <= '0;
      d_b_q      <= '0;
      d_rd_q     <= '0;
      x_valid_q  <= 1'b0;
      x_rd_q     <= '0;
      x_result_q <= '0;
      x_we_q     <= 1'b0;
      x_ill_q    <= 1'b0;
      retire_q   <= '0;
    end else begin
      d_valid_q  <= d_valid_d;
      d_op_q     <= d_op_d;
      d_a_q      <= d_a_d;
      d_b_q      <= d_b_d;
      d_rd_q     <= d_rd_d;
      x_valid_q  <= x_valid_d;
      x_rd_q     <= x_rd_d;
      x_result_q <= x_result_d;
      x_we_q     <= x_we_d;
      x_ill_q    <= x_ill_d;
      retire_q   <= retire_d;
    end
  end

  assign in_ready    = d_adv;
  assign out_valid   = x_valid_q;
  assign out_rd      = x_rd_q;
  assign out_result  = x_result_q;
  assign out_we      = x_we_q;
  assign out_illegal = x_ill_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_rv_exec_pipe.sv
// Scoreboard bench for rv_exec_pipe (XLEN=32): directed vectors, queue of expected results.
module tb_rv_exec_pipe;

  localparam int XLEN = 32;
  localparam int RW   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_val, rs2_val, out_result;
  logic [4:0]      out_rd;
  logic            out_we, out_illegal;
  logic [RW-1:0]   retire_cnt;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rv_exec_pipe #(.XLEN(XLEN), .RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_result(out_result), .out_we(out_we), .out_illegal(out_illegal),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each transferred result against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got rd=%0d res=0x%0h, expected no output", out_rd, out_result);
      end else begin
        chk("out_rd_res_we_ill", {out_rd, out_result, out_we, out_illegal}, sb.pop_front());
      end
    end
  end

  function automatic logic [31:0] rtype(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd);
    return {f7, 10'd0, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(logic [11:0] imm, logic [2:0] f3, logic [4:0] rd);
    return {imm, 5'd0, f3, rd, 7'b0010011};
  endfunction

  // Present one op, hold until accepted, push its expected result at the accepting edge.
  task automatic send(logic [31:0] ins, logic [31:0] a, logic [31:0] b, logic [31:0] res, logic ill);
    exp_t e;
    bit   done = 0;
    e.rd  = ins[11:7];
    e.res = res;
    e.ill = ill;
    e.we  = !ill && (ins[11:7] != 5'd0);
    in_valid = 1'b1;
    instr    = ins;
    rs1_val  = a;
    rs2_val  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    instr     = '0;
    rs1_val   = '0;
    rs2_val   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_retire_cnt", retire_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic R-type ops, back to back
    send(rtype(7'h00, 3'b000, 5'd2), 32'hF, 32'hC, 32'h1B, 0);
    send(rtype(7'h20, 3'b000, 5'd2), 32'hF, 32'hC, 32'h3, 0);
    send(rtype(7'h00, 3'b100, 5'd2), 32'hF, 32'hC, 32'h3, 0);
    send(rtype(7'h00, 3'b110, 5'd2), 32'hF, 32'hC, 32'hF, 0);
    send(rtype(7'h00, 3'b111, 5'd2), 32'hF, 32'hC, 32'hC, 0);
    // Shifts
    send(rtype(7'h00, 3'b001, 5'd3), 32'hFF0000FF, 32'h4, 32'hF0000FF0, 0);
    send(rtype(7'h00, 3'b101, 5'd3), 32'hFF0000FF, 32'h4, 32'h0FF0000F, 0);
    send(rtype(7'h20, 3'b101, 5'd3), 32'hFF0000FF, 32'h4, 32'hFFF0000F, 0);
    send(itype(12'h404, 3'b101, 5'd3), 32'hFF0000FF, 32'h0, 32'hFFF0000F, 0);
    send(rtype(7'h00, 3'b001, 5'd3), 32'h1, 32'h21, 32'h2, 0);
    // Compares
    send(rtype(7'h00, 3'b010, 5'd4), 32'h70000000, 32'hF0000000, 32'h0, 0);
    send(rtype(7'h00, 3'b011, 5'd4), 32'h70000000, 32'hF0000000, 32'h1, 0);
    send(itype(12'hFFF, 3'b010, 5'd4), 32'h0, 32'h0, 32'h0, 0);
    send(itype(12'hFFF, 3'b011, 5'd4), 32'h0, 32'h0, 32'h1, 0);
    send(itype(12'hFFE, 3'b000, 5'd4), 32'h5, 32'h0, 32'h3, 0);
    // Illegal encodings and the multiply extension
    send(32'h00000183, 32'hF, 32'hC, 32'h0, 1);
    send(itype(12'h7E1, 3'b001, 5'd6), 32'hF, 32'h0, 32'h0, 1);
    send(rtype(7'h20, 3'b111, 5'd6), 32'hF, 32'hC, 32'h0, 1);
`ifdef RV_EXEC_MUL_EN
    send(rtype(7'h01, 3'b000, 5'd5), 32'hF, 32'hC, 32'hB4, 0);
`else
    send(rtype(7'h01, 3'b000, 5'd5), 32'hF, 32'hC, 32'h0, 1);
`endif
    // rd = x0: result presented, no write
    send(rtype(7'h00, 3'b000, 5'd0), 32'hF, 32'hC, 32'h1B, 0);
    idle();
    drain();

    // Backpressure: reset first so retire_cnt starts at 0
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(rtype(7'h00, 3'b000, 5'(i + 1)), 32'(i), 32'h1, 32'(i + 1), 0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_result", out_result, 32'h1);
        repeat (2) begin
          @(negedge clk);
          chk("stall_hold_valid", out_valid, 1);
          chk("stall_hold_result", out_result, 32'h1);
          chk("stall_hold_rd", out_rd, 5'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("retire_after_stall", retire_cnt, 4);

    // Reset with both stages full drops the in-flight ops
    out_ready = 1'b0;
    send(rtype(7'h00, 3'b000, 5'd7), 32'h1, 32'h2, 32'h3, 0);
    send(rtype(7'h00, 3'b000, 5'd8), 32'h3, 32'h4, 32'h7, 0);
    idle();
    @(negedge clk);
    chk("full_before_rst", out_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_full_out_valid", out_valid, 0);
    chk("rst_full_retire", retire_cnt, 0);
    chk("rst_full_result", out_result, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    send(rtype(7'h00, 3'b000, 5'd9), 32'h10, 32'h20, 32'h30, 0);
    idle();
    @(negedge clk);
    chk("latency_edge1_valid", out_valid, 0);
    @(negedge clk);
    chk("latency_edge2_valid", out_valid, 1);
    drain();
    chk("retire_after_rst", retire_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
